lc3_pipe_controller: RTL and testbench

- Central control unit for the LC-3 five-stage pipeline.
- Consumes the control_in bus signals (IR, IR_Exec, Imem_dout, NZP, psr, complete_data, complete_instr).
- Drives the per-stage enables, operand bypass selects, branch-taken and the data-memory access state.
- Sequences stalls for memory instructions and flushes fetch after control-flow instructions.

---
 rtl/lc3_ctrl_pkg.sv | 39 +++
 rtl/lc3_pipe_controller_if.sv | 48 ++++
 rtl/lc3_mem_fsm.sv | 51 +++++
 rtl/lc3_pipe_controller.sv | 129 ++++++++++++
 tb/tb_lc3_pipe_controller.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/lc3_ctrl_pkg.sv
// rtl/lc3_ctrl_pkg.sv - LC-3 control opcodes, memory-state enum and opcode class helpers
package lc3_ctrl_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [1:0] {
        MEM_READ     = 2'd0,
        MEM_INDIRECT = 2'd1,
        MEM_WRITE    = 2'd2,
        MEM_IDLE     = 2'd3
    } mem_state_t;

    // Instructions whose result comes out of the ALU in execute
    function automatic logic is_alu_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
    endfunction

    // Instructions that touch data memory
    function automatic logic is_mem_op(input logic [3:0] op);
        return op inside {OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI};
    endfunction

    // Instructions whose result comes back from data memory
    function automatic logic is_load_op(input logic [3:0] op);
        return op inside {OP_LD, OP_LDR, OP_LDI};
    endfunction

endpackage

// File: rtl/lc3_pipe_controller_if.sv
// rtl/lc3_pipe_controller_if.sv - control bus between datapath and controller; LC3_CTRL_PERF_EN adds stall counters
interface lc3_pipe_controller_if;

    logic        complete_data;
    logic        complete_instr;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [15:0] Imem_dout;
    logic [2:0]  NZP;
    logic [2:0]  psr;

    logic        enable_updatePC;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        br_taken;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic [1:0]  mem_state;
`ifdef LC3_CTRL_PERF_EN
    logic [15:0] stall_mem_cnt;
    logic [15:0] stall_br_cnt;
`endif

    modport master (
`ifdef LC3_CTRL_PERF_EN
        input  stall_mem_cnt, stall_br_cnt,
`endif
        output complete_data, complete_instr, IR, IR_Exec, Imem_dout, NZP, psr,
        input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, bypass_mem_2, mem_state
    );

    modport slave (
`ifdef LC3_CTRL_PERF_EN
        output stall_mem_cnt, stall_br_cnt,
`endif
        input  complete_data, complete_instr, IR, IR_Exec, Imem_dout, NZP, psr,
        output enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, bypass_mem_2, mem_state
    );

endinterface

// File: rtl/lc3_mem_fsm.sv
// rtl/lc3_mem_fsm.sv - data-memory access sequencer with completion flag
module lc3_mem_fsm
    import lc3_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] exec_op,
    input  logic       complete_data,
    input  logic       enable_execute,
    output mem_state_t mem_state,
    output logic       mem_done
);

    // Walk IDLE -> (INDIRECT ->) READ/WRITE -> IDLE; mem_done marks the access as served
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_state <= MEM_IDLE;
            mem_done  <= 1'b0;
        end else begin
            // Execute advancing means the served instruction has left, so re-arm
            if (enable_execute) begin
                mem_done <= 1'b0;
            end
            case (mem_state)
                MEM_IDLE: begin
                    if (is_mem_op(exec_op) && !mem_done) begin
                        if (exec_op == OP_LDI || exec_op == OP_STI) begin
                            mem_state <= MEM_INDIRECT;
                        end else if (is_load_op(exec_op)) begin
                            mem_state <= MEM_READ;
                        end else begin
                            mem_state <= MEM_WRITE;
                        end
                    end
                end
                MEM_INDIRECT: begin
                    if (complete_data) begin
                        mem_state <= (exec_op == OP_STI) ? MEM_WRITE : MEM_READ;
                    end
                end
                default: begin
                    if (complete_data) begin
                        mem_state <= MEM_IDLE;
                        mem_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/lc3_pipe_controller.sv
// rtl/lc3_pipe_controller.sv - LC-3 pipeline enables, flush, bypass; LC3_CTRL_PERF_EN adds stall counters
module lc3_pipe_controller
    import lc3_ctrl_pkg::*;
#(
    parameter int BR_FLUSH_CYCLES = 3
) (
    input  logic clock,
    input  logic reset,
    lc3_pipe_controller_if.slave bus
);

    localparam logic [2:0] BR_LOAD = 3'(BR_FLUSH_CYCLES);

    logic [3:0] dec_op;
    logic [3:0] exec_op;
    logic [2:0] dst;
    mem_state_t mem_state;
    logic       mem_done;
    logic       mem_stall;
    logic [2:0] br_cnt;
    logic       en_updatepc;
    logic       en_fetch;
    logic       en_decode;
    logic       en_execute;
    logic       en_writeback;
    logic       src1_match;
    logic       src2_match;
    logic       unused_bits;

    assign dec_op  = bus.IR[15:12];
    assign exec_op = bus.IR_Exec[15:12];
    assign dst     = bus.IR_Exec[11:9];

    // Imem_dout and NZP ride the bus for the datapath; control decodes neither
    assign unused_bits = ^{bus.Imem_dout, bus.NZP, bus.IR, bus.IR_Exec};

    lc3_mem_fsm u_mem_fsm (
        .clock          (clock),
        .reset          (reset),
        .exec_op        (exec_op),
        .complete_data  (bus.complete_data),
        .enable_execute (en_execute),
        .mem_state      (mem_state),
        .mem_done       (mem_done)
    );

    assign mem_stall = (is_mem_op(exec_op) && !mem_done) || (mem_state != MEM_IDLE);

    // Flush counter: armed by BR/JMP in decode, frozen while memory stalls the pipe
    always_ff @(posedge clock) begin
        if (!reset) begin
            br_cnt <= 3'd0;
        end else if (!mem_stall) begin
            if (br_cnt != 3'd0) begin
                br_cnt <= br_cnt - 3'd1;
            end else if (dec_op == OP_BR || dec_op == OP_JMP) begin
                br_cnt <= BR_LOAD;
            end
        end
    end

    // Stage enables: memory stall freezes everything, flush freezes the front end
    always_comb begin
        en_updatepc  = 1'b0;
        en_fetch     = 1'b0;
        en_decode    = 1'b0;
        en_execute   = 1'b0;
        en_writeback = 1'b0;
        if (reset && !mem_stall) begin
            en_execute   = 1'b1;
            en_writeback = 1'b1;
            if (br_cnt != 3'd0) begin
                // Last flush cycle loads the resolved target into the PC
                en_updatepc = (br_cnt == 3'd1);
            end else begin
                en_updatepc = bus.complete_instr;
                en_fetch    = bus.complete_instr;
                en_decode   = 1'b1;
            end
        end
    end

    // Operand forwarding from the instruction in execute to the one in decode
    always_comb begin
        src1_match = (dec_op inside {OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR, OP_JMP})
                     && (bus.IR[8:6] == dst);
        src2_match = (dec_op inside {OP_ADD, OP_AND}) && !bus.IR[5]
                     && (bus.IR[2:0] == dst);
    end

    assign bus.enable_updatePC  = en_updatepc;
    assign bus.enable_fetch     = en_fetch;
    assign bus.enable_decode    = en_decode;
    assign bus.enable_execute   = en_execute;
    assign bus.enable_writeback = en_writeback;
    assign bus.mem_state        = mem_state;

    assign bus.br_taken = reset && ((exec_op == OP_JMP)
                          || (exec_op == OP_BR && ((bus.IR_Exec[11:9] & bus.psr) != 3'b000)));

    assign bus.bypass_alu_1 = reset && is_alu_op(exec_op) && src1_match;
    assign bus.bypass_alu_2 = reset && is_alu_op(exec_op) && src2_match;
    assign bus.bypass_mem_1 = reset && is_load_op(exec_op) && src1_match;
    assign bus.bypass_mem_2 = reset && is_load_op(exec_op) && src2_match;

`ifdef LC3_CTRL_PERF_EN
    logic [15:0] stall_mem_q;
    logic [15:0] stall_br_q;

    // Saturating counts of memory-stall cycles and flush cycles
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_mem_q <= 16'd0;
            stall_br_q  <= 16'd0;
        end else begin
            if (mem_stall && stall_mem_q != 16'hFFFF) begin
                stall_mem_q <= stall_mem_q + 16'd1;
            end
            if (br_cnt != 3'd0 && stall_br_q != 16'hFFFF) begin
                stall_br_q <= stall_br_q + 16'd1;
            end
        end
    end

    assign bus.stall_mem_cnt = stall_mem_q;
    assign bus.stall_br_cnt  = stall_br_q;
`endif

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// tb/tb_lc3_pipe_controller.sv - table-driven and sequence checks of lc3_pipe_controller
module tb_lc3_pipe_controller;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    lc3_pipe_controller_if bus ();

    lc3_pipe_controller #(.BR_FLUSH_CYCLES(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic [15:0] ir_exec;
        logic [2:0]  psr;
        logic        ci;
        logic        cd;
        logic [1:0]  st;
        logic [4:0]  en;
        logic        br;
        logic [3:0]  byp;
    } step_t;

    int    errors = 0;
    int    checks = 0;
    step_t sb[$];
    step_t vecs[15];

    function automatic step_t mk(input string name, input logic [15:0] ir, input logic [15:0] ir_exec,
                                 input logic [2:0] psr, input logic ci, input logic cd,
                                 input logic [1:0] st, input logic [4:0] en, input logic br,
                                 input logic [3:0] byp);
        step_t s;
        s.name = name; s.ir = ir; s.ir_exec = ir_exec; s.psr = psr; s.ci = ci; s.cd = cd;
        s.st = st; s.en = en; s.br = br; s.byp = byp;
        return s;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    // Drive one cycle of inputs, queue its expectation, compare on the falling edge
    task automatic apply_step(input step_t s);
        step_t e;
        bus.IR             = s.ir;
        bus.IR_Exec        = s.ir_exec;
        bus.psr            = s.psr;
        bus.complete_instr = s.ci;
        bus.complete_data  = s.cd;
        bus.Imem_dout      = s.ir;
        bus.NZP            = 3'b000;
        sb.push_back(s);
        @(negedge clock);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            check({e.name, ".mem_state"}, 16'(bus.mem_state), 16'(e.st));
            check({e.name, ".enables"}, 16'({bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
                                             bus.enable_execute, bus.enable_writeback}), 16'(e.en));
            check({e.name, ".br_taken"}, 16'(bus.br_taken), 16'(e.br));
            check({e.name, ".bypass"}, 16'({bus.bypass_alu_1, bus.bypass_alu_2,
                                            bus.bypass_mem_1, bus.bypass_mem_2}), 16'(e.byp));
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single-cycle vectors, each applied in the first cycle after a reset
        vecs[0]  = mk("t_add_add",  16'h1641, 16'h1240, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b1100);
        vecs[1]  = mk("t_ld_fwd",   16'h1641, 16'h2200, 3'b000, 1, 0, 2'd3, 5'b00000, 0, 4'b0011);
        vecs[2]  = mk("t_and_fwd",  16'h1641, 16'h5240, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b1100);
        vecs[3]  = mk("t_imm",      16'h1661, 16'h1240, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b1000);
        vecs[4]  = mk("t_ldr",      16'h6240, 16'h1240, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b1000);
        vecs[5]  = mk("t_jmp_lea",  16'hC040, 16'hE200, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b1000);
        vecs[6]  = mk("t_br_taken", 16'h1000, 16'h0800, 3'b100, 0, 0, 2'd3, 5'b00111, 1, 4'b0000);
        vecs[7]  = mk("t_br_not",   16'h1000, 16'h0800, 3'b010, 1, 0, 2'd3, 5'b11111, 0, 4'b0000);
        vecs[8]  = mk("t_jmp_exec", 16'h1000, 16'hC1C0, 3'b000, 1, 0, 2'd3, 5'b11111, 1, 4'b0000);
        vecs[9]  = mk("t_src2",     16'h1681, 16'h1240, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b0100);
        vecs[10] = mk("t_not_fwd",  16'h1641, 16'h927F, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b1100);
        vecs[11] = mk("t_ldi_str",  16'h7240, 16'hA200, 3'b000, 1, 0, 2'd3, 5'b00000, 0, 4'b0010);
        vecs[12] = mk("t_nomatch",  16'h1641, 16'h1440, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b0000);
        vecs[13] = mk("t_brnzp",    16'h0000, 16'h0E00, 3'b001, 1, 0, 2'd3, 5'b11111, 1, 4'b0000);
        vecs[14] = mk("t_st",       16'h1641, 16'h3200, 3'b000, 1, 0, 2'd3, 5'b00000, 0, 4'b0000);

        // Reset held low three cycles: everything gated, then full enables on release
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            apply_step(mk("rst_hold", 16'h1641, 16'h1240, 3'b111, 1, 0, 2'd3, 5'b00000, 0, 4'b0000));
        reset = 1'b1;
        apply_step(mk("rst_release", 16'h1641, 16'h1240, 3'b111, 1, 0, 2'd3, 5'b11111, 0, 4'b1100));

        for (int i = 0; i < 15; i++) begin
            do_reset();
            apply_step(vecs[i]);
        end

        // LDI: IDLE -> INDIRECT -> READ -> IDLE, execute resumes after return
        do_reset();
        apply_step(mk("ldi_0", 16'h1FFF, 16'hA000, 3'b000, 1, 0, 2'd3, 5'b00000, 0, 4'b0000));
        apply_step(mk("ldi_1", 16'h1FFF, 16'hA000, 3'b000, 1, 0, 2'd1, 5'b00000, 0, 4'b0000));
        apply_step(mk("ldi_2", 16'h1FFF, 16'hA000, 3'b000, 1, 1, 2'd1, 5'b00000, 0, 4'b0000));
        apply_step(mk("ldi_3", 16'h1FFF, 16'hA000, 3'b000, 1, 0, 2'd0, 5'b00000, 0, 4'b0000));
        apply_step(mk("ldi_4", 16'h1FFF, 16'hA000, 3'b000, 1, 1, 2'd0, 5'b00000, 0, 4'b0000));
        apply_step(mk("ldi_5", 16'h1FFF, 16'hA000, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b0000));
        apply_step(mk("ldi_6", 16'h1FFF, 16'h1000, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b0000));

        // ST goes straight to WRITE; STI goes INDIRECT then WRITE
        do_reset();
        apply_step(mk("st_0",  16'h1FFF, 16'h3000, 3'b000, 1, 0, 2'd3, 5'b00000, 0, 4'b0000));
        apply_step(mk("st_1",  16'h1FFF, 16'h3000, 3'b000, 1, 0, 2'd2, 5'b00000, 0, 4'b0000));
        apply_step(mk("st_2",  16'h1FFF, 16'h3000, 3'b000, 1, 1, 2'd2, 5'b00000, 0, 4'b0000));
        apply_step(mk("st_3",  16'h1FFF, 16'h3000, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b0000));
        apply_step(mk("sti_0", 16'h1FFF, 16'hB000, 3'b000, 1, 0, 2'd3, 5'b00000, 0, 4'b0000));
        apply_step(mk("sti_1", 16'h1FFF, 16'hB000, 3'b000, 1, 1, 2'd1, 5'b00000, 0, 4'b0000));
        apply_step(mk("sti_2", 16'h1FFF, 16'hB000, 3'b000, 1, 1, 2'd2, 5'b00000, 0, 4'b0000));
        apply_step(mk("sti_3", 16'h1FFF, 16'hB000, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b0000));
        apply_step(mk("sti_4", 16'h1FFF, 16'h1000, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b0000));

        // BR n in decode: three flush cycles, PC loads on the last one
        do_reset();
        apply_step(mk("br_0", 16'h0800, 16'h1000, 3'b100, 1, 0, 2'd3, 5'b11111, 0, 4'b0000));
        apply_step(mk("br_1", 16'h1FFF, 16'h0800, 3'b100, 1, 0, 2'd3, 5'b00011, 1, 4'b0000));
        apply_step(mk("br_2", 16'h1FFF, 16'h1000, 3'b100, 1, 0, 2'd3, 5'b00011, 0, 4'b0000));
        apply_step(mk("br_3", 16'h1FFF, 16'h1000, 3'b100, 1, 0, 2'd3, 5'b10011, 0, 4'b0000));
        apply_step(mk("br_4", 16'h1FFF, 16'h1000, 3'b100, 1, 0, 2'd3, 5'b11111, 0, 4'b0000));

        // BR waiting in decode behind a load: flush starts only after the access completes
        do_reset();
        apply_step(mk("brst_0", 16'h0800, 16'h2200, 3'b000, 1, 0, 2'd3, 5'b00000, 0, 4'b0000));
        apply_step(mk("brst_1", 16'h0800, 16'h2200, 3'b000, 1, 0, 2'd0, 5'b00000, 0, 4'b0000));
        apply_step(mk("brst_2", 16'h0800, 16'h2200, 3'b000, 1, 1, 2'd0, 5'b00000, 0, 4'b0000));
        apply_step(mk("brst_3", 16'h0800, 16'h2200, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b0000));
        apply_step(mk("brst_4", 16'h1FFF, 16'h0800, 3'b000, 1, 0, 2'd3, 5'b00011, 0, 4'b0000));
        apply_step(mk("brst_5", 16'h1FFF, 16'h1000, 3'b000, 1, 0, 2'd3, 5'b00011, 0, 4'b0000));
        apply_step(mk("brst_6", 16'h1FFF, 16'h1000, 3'b000, 1, 0, 2'd3, 5'b10011, 0, 4'b0000));
        apply_step(mk("brst_7", 16'h1FFF, 16'h1000, 3'b000, 1, 0, 2'd3, 5'b11111, 0, 4'b0000));

        // Reset in the middle of a read: FSM back to IDLE, late complete_data ignored
        do_reset();
        apply_step(mk("midrst_0", 16'h1FFF, 16'h2200, 3'b000, 1, 0, 2'd3, 5'b00000, 0, 4'b0000));
        apply_step(mk("midrst_1", 16'h1FFF, 16'h2200, 3'b000, 1, 0, 2'd0, 5'b00000, 0, 4'b0000));
        reset = 1'b0;
        apply_step(mk("midrst_2", 16'h1FFF, 16'h2200, 3'b000, 1, 1, 2'd0, 5'b00000, 0, 4'b0000));
        apply_step(mk("midrst_3", 16'h1FFF, 16'h2200, 3'b000, 1, 1, 2'd3, 5'b00000, 0, 4'b0000));
        reset = 1'b1;
        apply_step(mk("midrst_4", 16'h1FFF, 16'h1000, 3'b000, 1, 1, 2'd3, 5'b11111, 0, 4'b0000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
